// File: rtl/psx_ctrl_pkg.sv
// PSX controller shared constants, state encoding and snapshot bundle.
// Reply byte lookup lives here so the top stays a pure sequencer.
package psx_ctrl_pkg;

  localparam logic [7:0] ID_DIGITAL   = 8'h41;
  localparam logic [7:0] ID_ANALOGR   = 8'h73;
  localparam logic [7:0] START_COMM   = 8'h01;
  localparam logic [7:0] DATA_REQUEST = 8'h42;
  localparam logic [7:0] DATA_READY   = 8'h5A;
  localparam logic [7:0] NO_DATA      = 8'hFF;
  localparam logic [7:0] STICK_MID    = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACK_WAIT,
    ACK_LOW,
    ABORT
  } state_t;

  typedef struct packed {
    logic        analog;
    logic [15:0] btn;
    logic [7:0]  rjx;
    logic [7:0]  rjy;
    logic [7:0]  ljx;
    logic [7:0]  ljy;
  } snap_t;

  function automatic logic [7:0] reply_byte(
    input snap_t      s,
    input logic [3:0] n
  );
    logic [7:0] r;
    case (n)
      4'd1:    r = NO_DATA;
      4'd2:    r = s.analog ? ID_ANALOGR : ID_DIGITAL;
      4'd3:    r = DATA_READY;
      4'd4:    r = s.btn[7:0];
      4'd5:    r = s.btn[15:8];
      4'd6:    r = s.rjx;
      4'd7:    r = s.rjy;
      4'd8:    r = s.ljx;
      4'd9:    r = s.ljy;
      default: r = NO_DATA;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] last_byte(input snap_t s);
    return s.analog ? 4'd9 : 4'd5;
  endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchronizer for one host pin with rise/fall pulses
// taken from the synchronized level.
module psx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/controller_device.sv
// PSX pad device side: byte shifter, ACK timing and poll sequencing.
// Analog pad reporting is built only with CTRL_DEVICE_ANALOG_EN.
module controller_device
  import psx_ctrl_pkg::*;
#(
  parameter int ACK_DLY = 20,
  parameter int ACK_LEN = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ATT,
  input  logic        c_clk,
  input  logic        COMMAND,
  output logic        DATA,
  output logic        ACK,
  input  logic        analog_mode,
  input  logic [15:0] btn,
  input  logic [7:0]  RJOY_X,
  input  logic [7:0]  RJOY_Y,
  input  logic [7:0]  LJOY_X,
  input  logic [7:0]  LJOY_Y,
  output logic        busy,
  output logic        poll_done
);

  localparam int CNT_MAX = (ACK_DLY > ACK_LEN) ? ACK_DLY : ACK_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic att_q, att_rise, att_fall;
  logic ck_q, ck_rise, ck_fall;
  logic cmd_q, cmd_rise, cmd_fall;

  psx_sync_edge u_att (
    .clk (clk),
    .rst (rst),
    .d   (ATT),
    .q   (att_q),
    .rise(att_rise),
    .fall(att_fall)
  );

  psx_sync_edge u_ck (
    .clk (clk),
    .rst (rst),
    .d   (c_clk),
    .q   (ck_q),
    .rise(ck_rise),
    .fall(ck_fall)
  );

  psx_sync_edge u_cmd (
    .clk (clk),
    .rst (rst),
    .d   (COMMAND),
    .q   (cmd_q),
    .rise(cmd_rise),
    .fall(cmd_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{att_rise, ck_q, cmd_rise, cmd_fall};

  state_t        state, state_d;
  logic [3:0]    byte_no, byte_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    rx, rx_d;
  logic          data_q, data_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt, cnt_d;
  snap_t         snap, snap_d, cap;

  always_comb begin
    cap.btn = btn;
`ifdef CTRL_DEVICE_ANALOG_EN
    cap.analog = analog_mode;
    cap.rjx    = RJOY_X;
    cap.rjy    = RJOY_Y;
    cap.ljx    = LJOY_X;
    cap.ljy    = LJOY_Y;
`else
    cap.analog = 1'b0;
    cap.rjx    = STICK_MID;
    cap.rjy    = STICK_MID;
    cap.ljx    = STICK_MID;
    cap.ljy    = STICK_MID;
`endif
  end

`ifndef CTRL_DEVICE_ANALOG_EN
  logic unused_inputs;
  assign unused_inputs =
    ^{analog_mode, RJOY_X, RJOY_Y, LJOY_X, LJOY_Y};
`endif

  logic [7:0] cur_byte;
  logic [7:0] byte_in;
  logic       bad_hdr;

  assign cur_byte = reply_byte(snap, byte_no);
  assign byte_in  = {cmd_q, rx[6:0]};
  assign bad_hdr  =
    (byte_no == 4'd1 && byte_in != START_COMM) ||
    (byte_no == 4'd2 && byte_in != DATA_REQUEST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      byte_no <= 4'd1;
      idx     <= 3'd0;
      rx      <= 8'h00;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
      cnt     <= '0;
      snap    <= '{analog: 1'b0, btn: 16'hFFFF,
                   rjx: STICK_MID, rjy: STICK_MID,
                   ljx: STICK_MID, ljy: STICK_MID};
    end else begin
      state   <= state_d;
      byte_no <= byte_d;
      idx     <= idx_d;
      rx      <= rx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt     <= cnt_d;
      snap    <= snap_d;
    end
  end

  always_comb begin
    state_d = state;
    byte_d  = byte_no;
    idx_d   = idx;
    rx_d    = rx;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt;
    snap_d  = snap;
    case (state)
      IDLE: begin
        data_d = 1'b1;
        if (att_fall) begin
          state_d = SHIFT;
          byte_d  = 4'd1;
          idx_d   = 3'd0;
          snap_d  = cap;
        end
      end
      SHIFT: begin
        if (ck_fall) data_d = cur_byte[idx];
        if (ck_rise) begin
          rx_d[idx] = cmd_q;
          idx_d     = idx + 3'd1;
          if (idx == 3'd7) begin
            data_d = 1'b1;
            if (byte_no == last_byte(snap)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (bad_hdr) begin
              state_d = ABORT;
            end else begin
              state_d = ACK_WAIT;
              cnt_d   = '0;
            end
          end
        end
      end
      ACK_WAIT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(ACK_DLY - 1)) begin
          state_d = ACK_LOW;
          cnt_d   = '0;
        end
      end
      ACK_LOW: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(ACK_LEN - 1)) begin
          state_d = SHIFT;
          byte_d  = byte_no + 4'd1;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      ABORT: data_d = 1'b1;
      default: state_d = IDLE;
    endcase
    // host deselect wins over everything else mid-poll
    if (att_q && state != IDLE) begin
      state_d = IDLE;
      data_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  assign DATA      = data_q;
  assign ACK       = (state != ACK_LOW);
  assign busy      = (state != IDLE);
  assign poll_done = done_q;

endmodule
